// File: rtl/er_dma_initiator.sv
// ============================================================================
// Module      : er_dma_initiator
// Description : Single-channel word-copy DMA initiator for the openMSP430 DMA
//               port, deferring bus beats while the CPU executes inside the
//               protected region with exec still valid.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module er_dma_initiator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             force_i,
  input  logic             abort_i,
  input  logic [15:0]      src_i,
  input  logic [15:0]      dst_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [15:0]      pc_i,
  input  logic [15:0]      er_min_i,
  input  logic [15:0]      er_max_i,
  input  logic             exec_i,
  output logic             dma_en_o,
  output logic [14:0]      dma_addr_o,
  output logic [1:0]       dma_we_o,
  output logic [15:0]      dma_din_o,
  input  logic [15:0]      dma_dout_i,
  input  logic             dma_ready_i,
  input  logic             dma_resp_i,
  output logic             busy_o,
  output logic             deferred_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] remaining_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GATE    = 3'd1,
    S_WAIT_ER = 3'd2,
    S_RD      = 3'd3,
    S_WR      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      src_q, src_d;
  logic [15:0]      dst_q, dst_d;
  logic [15:0]      data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             abort_q, abort_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic w_hold;
  logic w_abort_req;

  // Defer while the CPU is inside the protected region and exec is still valid.
  assign w_hold      = exec_i && (pc_i >= er_min_i) && (pc_i <= er_max_i) && !force_i;
  assign w_abort_req = abort_i || abort_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    rem_d   = rem_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start_i) begin
          if (count_i != '0) begin
            src_d   = src_i;
            dst_d   = dst_i;
            rem_d   = count_i;
            state_d = S_GATE;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_GATE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (w_hold) begin
          state_d = S_WAIT_ER;
        end else begin
          state_d = S_RD;
        end
      end

      S_WAIT_ER: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (!w_hold) begin
          state_d = S_RD;
        end
      end

      // An abort during a beat is remembered until the beat finishes.
      S_RD: begin
        if (abort_i) begin
          abort_d = 1'b1;
        end
        if (dma_ready_i) begin
          abort_d = 1'b0;
          if (dma_resp_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (w_abort_req) begin
            state_d = S_IDLE;
          end else begin
            data_d  = dma_dout_i;
            state_d = S_WR;
          end
        end
      end

      S_WR: begin
        if (abort_i) begin
          abort_d = 1'b1;
        end
        if (dma_ready_i) begin
          abort_d = 1'b0;
          if (dma_resp_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (w_abort_req) begin
            state_d = S_IDLE;
          end else begin
            src_d = src_q + 16'd2;
            dst_d = dst_q + 16'd2;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_GATE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs decode straight from registered state, so they hold while stalled.
  assign dma_en_o    = (state_q == S_RD) || (state_q == S_WR);
  assign dma_we_o    = (state_q == S_WR) ? 2'b11 : 2'b00;
  assign dma_addr_o  = (state_q == S_RD) ? src_q[15:1] :
                       (state_q == S_WR) ? dst_q[15:1] : 15'd0;
  assign dma_din_o   = (state_q == S_WR) ? data_q : 16'd0;
  assign busy_o      = (state_q != S_IDLE);
  assign deferred_o  = (state_q == S_WAIT_ER);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign remaining_o = rem_q;

endmodule

`default_nettype wire

// File: doc/er_dma_initiator.md
# er_dma_initiator

Single-channel word-copy DMA initiator that drives the openMSP430 DMA port whose `dma_en` is watched by the VAPE IRQ/DMA exec monitor. It copies `count` 16-bit words from `src` to `dst`. By default it defers every bus beat while the CPU executes inside the protected region with `exec` still valid, so routine DMA does not void an attestation in progress. A force input lets the platform override this deferral deliberately.

## Interface
Parameters:
- CNT_W, 16, width of the transfer word count

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  launch request; sampled only in IDLE
- force  in  1  ignore ER deferral (sampled at every gate check)
- abort  in  1  cancel the transfer in progress
- src  in  16  source byte address, latched at start, bit 0 ignored
- dst  in  16  destination byte address, latched at start, bit 0 ignored
- count  in  CNT_W  number of words to copy, latched at start
- pc  in  16  current CPU program counter
- ER_min  in  16  protected region lower bound, inclusive
- ER_max  in  16  protected region upper bound, inclusive
- exec  in  1  exec flag from the monitor
- dma_en  out  1  DMA bus request
- dma_addr  out  15  word address (byte address [15:1])
- dma_we  out  2  byte write enables; 00 = read, 11 = write
- dma_din  out  16  write data
- dma_dout  in  16  read data
- dma_ready  in  1  beat complete
- dma_resp  in  1  bus error, valid with dma_ready
- busy  out  1  high in every state except IDLE
- deferred  out  1  high while in WAIT_ER
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on bus error
- remaining  out  CNT_W  words not yet written

## Operation
- States: IDLE, GATE, WAIT_ER, RD, WR.
- The defer condition `hold` is `exec && pc>=ER_min && pc<=ER_max && !force`. It uses unsigned compares and is combinational on the current inputs.
- IDLE:
  - On `start` with `count`≠0: latch `src`, `dst` and `count`; go to GATE.
  - On `start` with `count`==0: pulse `done` next cycle; no bus activity; stay IDLE.
- GATE: if `hold`, go to WAIT_ER; otherwise go to RD.
- WAIT_ER: `dma_en`=0. Leave for RD in the first cycle where `hold`=0.
- RD:
  - Drive `dma_en`=1, `dma_we`=00, `dma_addr`=src[15:1].
  - On `dma_ready` with `dma_resp`=0: capture `dma_dout` into the data register; go to WR.
- WR:
  - Drive `dma_en`=1, `dma_we`=11, `dma_addr`=dst[15:1], `dma_din`=data.
  - On `dma_ready` with `dma_resp`=0: src+=2, dst+=2 (mod 2^16 wrap), remaining-=1.
  - If remaining becomes 0: go to IDLE with a `done` pulse. Otherwise go to GATE.
- Bus error: `dma_ready` with `dma_resp`=1 in RD or WR goes to IDLE with an `err` pulse. No counter or address update.
- Abort:
  - In GATE or WAIT_ER: go to IDLE next cycle.
  - In RD or WR: the current beat completes first. On `dma_ready`, go to IDLE without updating counters (even on a successful write).
  - No `done` or `err` pulse on abort unless `dma_resp`=1 on that beat, which gives `err`.
- Outputs are stable while `dma_ready`=0. Once asserted, `dma_en` stays high until `dma_ready`.

## Timing
- Reset values: state IDLE; `dma_en`, `dma_we`, `dma_addr`, `dma_din`, `busy`, `deferred`, `done`, `err`, `remaining` all 0.
- Reset mid-beat drops `dma_en` immediately.
- `start` in cycle N: GATE in N+1; `dma_en` rises in N+2 when not deferred.
- One word with zero-wait `dma_ready`: RD 1 cycle, WR 1 cycle, then GATE 1 cycle. Throughput is 3 cycles per word; `done` is asserted in the cycle after the last WR.
- `hold` falling in cycle M while in WAIT_ER: RD (`dma_en`=1) in M+1.
- `hold` rising while in RD or WR does not stall that beat; it applies at the next GATE.
- `start` while busy is ignored.

## Test plan
- Copy 3 words from 0x0200 to 0x0400 with `exec`=0 and zero-wait bus -> reads at word addresses 0x100–0x102, writes at 0x200–0x202 with matching data; `done` pulses at cycle 10 after `start`; `remaining`=0.
- `exec`=1, pc=0xE010, ER range 0xE000–0xE0FF, count=2 -> `deferred`=1 and `dma_en`=0 throughout. Move pc to 0xF000 -> RD starts the next cycle; transfer completes.
- Same as the previous case with `force`=1 -> no WAIT_ER; `dma_en` asserted at start+2.
- `dma_resp`=1 on the second RD of count=4 -> `err` pulse; `remaining`=3; IDLE; no further `dma_en`.
- `abort` during a WR stalled 3 cycles on `dma_ready` -> `dma_en` held until ready; then IDLE with `remaining` unchanged and no `done`.
- src=0xFFFE, count=2 -> second read at word address 0x0000 (wrap); `start` with count=0 -> `done` pulse only, no `dma_en`.
